// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a character FIFO in front of it.
//
// Characters written on i_data/i_wr are queued in a circular FIFO. A
// start/data/parity/stop state machine drains the FIFO and serialises each
// character onto o_UART_Tx, LSB first. Frames are sent back to back while the
// FIFO holds data, with no idle bit between them.
//
// Ports:
//   i_clk       sole clock, rising edge
//   i_rst       asynchronous active-low reset; release is registered internally
//   i_data      character to queue (G_DATA_BITS wide)
//   i_wr        single-cycle write strobe
//   o_full      FIFO holds G_FIFO_DEPTH entries (registered)
//   o_busy      frame in progress or FIFO non-empty
//   o_overflow  one-cycle pulse after a write that was rejected because o_full was high
//   o_UART_Tx   serial line, idle high, driven straight from a flop
//
// Write handshake: i_wr is a one-cycle strobe with no ready signal. A write is
// taken at the rising edge where i_wr=1 and o_full=0. With o_full=1 the
// character is dropped and o_overflow pulses the following cycle. A pop in
// the same cycle never frees room for that write, because o_full is a register.
module uart_tx_fifo #(
  parameter int G_CLK_DIV    = 868,
  parameter int G_DATA_BITS  = 8,
  parameter int G_PARITY     = 0,
  parameter int G_STOP_BITS  = 1,
  parameter int G_FIFO_DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [G_DATA_BITS-1:0] i_data,
  input  logic                   i_wr,
  output logic                   o_full,
  output logic                   o_busy,
  output logic                   o_overflow,
  output logic                   o_UART_Tx
);

  localparam int AW = $clog2(G_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(G_CLK_DIV);
  localparam int BW = $clog2(G_DATA_BITS);

  localparam logic [TW-1:0] BIT_RELOAD = TW'(G_CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_DATA  = BW'(G_DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP  = BW'(G_STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(G_FIFO_DEPTH);
  localparam logic          PAR_ODD    = (G_PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Reset release is taken through one flop: nothing moves on the first edge
  // after release, and the first write is accepted on the second edge.
  logic run;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) run <= 1'b0;
    else        run <= 1'b1;
  end

  // FIFO storage and control
  logic [G_DATA_BITS-1:0] mem [G_FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_n;
  logic                   full_q, ovf_q;
  logic                   push, pop, pop_req;
  logic [G_DATA_BITS-1:0] head;

  assign push    = run && i_wr && !full_q;
  assign pop     = run && pop_req;
  assign count_n = count + CW'(push) - CW'(pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (run) begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count  <= count_n;
      full_q <= (count_n == DEPTH_C);
      ovf_q  <= i_wr && full_q;
    end
  end

  // Transmitter state machine
  state_t                 state, state_n;
  logic [TW-1:0]          timer, timer_n;
  logic [BW-1:0]          bit_cnt, bit_cnt_n;
  logic [G_DATA_BITS-1:0] shift, shift_n;
  logic                   par, par_n;
  logic                   tx_q, line_n;
  logic                   load;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx_q    <= 1'b1;
    end else if (run) begin
      state   <= state_n;
      timer   <= timer_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par     <= par_n;
      tx_q    <= line_n;
    end
  end

  // line_n is the level belonging to the current state; it reaches the pin
  // through tx_q one cycle later, so the line lags the state by one cycle.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    line_n    = 1'b1;
    load      = 1'b0;
    pop_req   = 1'b0;

    case (state)
      S_IDLE: begin
        if (count != '0) load = 1'b1;
      end
      S_START: begin
        line_n = 1'b0;
        if (timer == '0) begin
          timer_n   = BIT_RELOAD;
          bit_cnt_n = '0;
          state_n   = S_DATA;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      S_DATA: begin
        line_n = shift[0];
        if (timer == '0) begin
          timer_n = BIT_RELOAD;
          shift_n = shift >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = '0;
            state_n   = (G_PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      S_PARITY: begin
        line_n = par;
        if (timer == '0) begin
          timer_n   = BIT_RELOAD;
          bit_cnt_n = '0;
          state_n   = S_STOP;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      S_STOP: begin
        if (timer == '0) begin
          if (bit_cnt == LAST_STOP) begin
            // Chain straight into the next start bit when data is waiting.
            if (count != '0) load    = 1'b1;
            else             state_n = S_IDLE;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
            timer_n   = BIT_RELOAD;
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Pop the head character and prepare its start bit; parity is worked out
    // once here rather than accumulated while shifting.
    if (load) begin
      pop_req = 1'b1;
      shift_n = head;
      par_n   = (^head) ^ PAR_ODD;
      timer_n = BIT_RELOAD;
      state_n = S_START;
    end
  end

  assign o_full     = full_q;
  assign o_overflow = ovf_q;
  assign o_busy     = (state != S_IDLE) || (count != '0);
  assign o_UART_Tx  = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// Three instances at G_CLK_DIV=4:
//   u_a: defaults otherwise (no parity, 1 stop, depth 16)
//   u_b: even parity, depth 4
//   u_c: odd parity, 2 stop bits
// Each received frame is deserialised from the line and checked against the
// expected queue, with start, parity and stop bits and bit widths checked too.
module tb_uart_tx_fifo;

  localparam int DIV = 4;

  logic            clk = 1'b0;
  logic [2:0]      rst, wr;
  logic [2:0][7:0] data;
  logic [2:0]      full, busy, ovf, txl;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_start, last_end;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx_fifo #(.G_CLK_DIV(DIV)) u_a (
    .i_clk(clk), .i_rst(rst[0]), .i_data(data[0]), .i_wr(wr[0]),
    .o_full(full[0]), .o_busy(busy[0]), .o_overflow(ovf[0]), .o_UART_Tx(txl[0])
  );

  uart_tx_fifo #(.G_CLK_DIV(DIV), .G_PARITY(2), .G_FIFO_DEPTH(4)) u_b (
    .i_clk(clk), .i_rst(rst[1]), .i_data(data[1]), .i_wr(wr[1]),
    .o_full(full[1]), .o_busy(busy[1]), .o_overflow(ovf[1]), .o_UART_Tx(txl[1])
  );

  uart_tx_fifo #(.G_CLK_DIV(DIV), .G_PARITY(1), .G_STOP_BITS(2)) u_c (
    .i_clk(clk), .i_rst(rst[2]), .i_data(data[2]), .i_wr(wr[2]),
    .o_full(full[2]), .o_busy(busy[2]), .o_overflow(ovf[2]), .o_UART_Tx(txl[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following rising edge.
  task automatic write(input int k, input logic [7:0] d);
    data[k] = d;
    wr[k]   = 1'b1;
    @(negedge clk);
    wr[k]   = 1'b0;
  endtask

  task automatic idle_check(input int k, input int n, input string tag);
    int lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (txl[k] !== 1'b1) lows++;
    end
    chk(tag, lows, 0);
  endtask

  // Deserialise one frame (8 data bits) from instance k, sampling every cycle
  // of every bit. Returns at the negedge just after the last stop cycle.
  task automatic rx_frame(input int k, input int np, input int ns, input string tag);
    int         t = 0;
    int         nb;
    int         unstable = 0;
    logic [15:0] s = '0;
    logic       first = 1'b1;
    logic [7:0] exp, got;
    logic       exp_par;
    while (txl[k] !== 1'b0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_start_seen"}, (t < 600), 1);
    if (t >= 600) return;
    last_start = cyc;
    nb = 1 + 8 + ((np != 0) ? 1 : 0) + ns;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < DIV; c++) begin
        if (c == 0) first = txl[k];
        else if (txl[k] !== first) unstable++;
        if (c == DIV / 2) s[b] = txl[k];
        @(negedge clk);
      end
    end
    last_end = cyc;
    chk({tag, "_exp_avail"}, (exp_q.size() != 0), 1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    got = s[8:1];
    chk({tag, "_start_bit"}, s[0], 0);
    chk({tag, "_data"}, got, exp);
    if (np != 0) begin
      exp_par = (np == 2) ? (^exp) : ~(^exp);
      chk({tag, "_parity"}, s[9], exp_par);
    end
    for (int i = 0; i < ns; i++) chk({tag, "_stop"}, s[9 + ((np != 0) ? 1 : 0) + i], 1);
    chk({tag, "_bit_width"}, unstable, 0);
  endtask

  initial begin
    int w_cyc, s0;
    rst  = '1;
    wr   = '0;
    data = '0;
    #1 rst = '0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_line", txl[k], 1);
      chk("rst_busy", busy[k], 0);
      chk("rst_full", full[k], 0);
      chk("rst_ovf", ovf[k], 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = '1;
    @(negedge clk);
    @(negedge clk);

    // 0x48, no parity: latency, bit pattern, 40-cycle frame, busy release
    exp_q.push_back(8'h48);
    write(0, 8'h48);
    w_cyc = cyc;
    chk("a_lat_line_high", txl[0], 1);
    chk("a_busy_on", busy[0], 1);
    rx_frame(0, 0, 1, "a48");
    chk("a_latency", last_start - w_cyc, 2);
    chk("a_frame_len", last_end - last_start, 40);
    chk("a_idle_line", txl[0], 1);
    chk("a_busy_off", busy[0], 0);

    // 0x07, even parity (bit 1), 44-cycle frame
    exp_q.push_back(8'h07);
    write(1, 8'h07);
    rx_frame(1, 2, 1, "b07");
    chk("b_frame_len", last_end - last_start, 44);
    chk("b_busy_off", busy[1], 0);

    // 0x07 then 0xC3, odd parity, 2 stop bits, back to back
    exp_q.push_back(8'h07);
    exp_q.push_back(8'hC3);
    fork
      begin
        rx_frame(2, 1, 2, "c07");
        s0 = last_start;
        rx_frame(2, 1, 2, "cC3");
        chk("c_b2b_start_gap", last_start - s0, 48);
        chk("c_frame_len", last_end - last_start, 48);
      end
      begin
        write(2, 8'h07);
        write(2, 8'hC3);
      end
    join
    chk("c_busy_off", busy[2], 0);

    // Depth 4: six consecutive writes, one popped, four queued, sixth dropped
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    fork
      begin
        repeat (5) rx_frame(1, 2, 1, "b_ovf");
      end
      begin
        data[1] = 8'h11; wr[1] = 1'b1;
        @(negedge clk);
        data[1] = 8'h22;
        @(negedge clk);
        data[1] = 8'h33;
        @(negedge clk);
        chk("b_full_after3", full[1], 0);
        data[1] = 8'h44;
        @(negedge clk);
        chk("b_full_after4", full[1], 0);
        data[1] = 8'h55;
        @(negedge clk);
        chk("b_full_after5", full[1], 1);
        chk("b_ovf_after5", ovf[1], 0);
        data[1] = 8'h66;
        @(negedge clk);
        wr[1] = 1'b0;
        chk("b_ovf_pulse", ovf[1], 1);
        chk("b_full_after6", full[1], 1);
        @(negedge clk);
        chk("b_ovf_one_cycle", ovf[1], 0);
        chk("b_full_held", full[1], 1);
      end
    join
    idle_check(1, 60, "b_no_sixth_char");
    chk("b_busy_end", busy[1], 0);
    chk("b_full_end", full[1], 0);

    // Reset mid-DATA with three characters queued
    write(0, 8'hA5);
    write(0, 8'h3C);
    write(0, 8'h5A);
    write(0, 8'hF0);
    chk("a_full_before_rst", full[0], 0);
    repeat (8) @(negedge clk);
    chk("a_pre_rst_line", txl[0], 0);
    chk("a_pre_rst_busy", busy[0], 1);
    #2 rst[0] = 1'b0;
    #1;
    chk("a_rst_line_now", txl[0], 1);
    chk("a_rst_busy_now", busy[0], 0);
    chk("a_rst_full_now", full[0], 0);
    chk("a_rst_ovf_now", ovf[0], 0);
    @(negedge clk);
    chk("a_rst_line_held", txl[0], 1);
    @(negedge clk);
    rst[0]  = 1'b1;
    data[0] = 8'h81;
    wr[0]   = 1'b1;
    @(negedge clk);
    chk("a_first_edge_ignored", busy[0], 0);
    data[0] = 8'h42;
    @(negedge clk);
    wr[0] = 1'b0;
    chk("a_second_edge_taken", busy[0], 1);
    exp_q.push_back(8'h42);
    rx_frame(0, 0, 1, "a_post_rst");
    idle_check(0, 100, "a_flushed_no_more");
    chk("a_busy_final", busy[0], 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter G_CLK_DIV, default 868, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL provide parameter G_DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL provide parameter G_PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL provide parameter G_STOP_BITS, default 1, stop bits per frame: 1 or 2.
REQ-005 SHALL provide parameter G_FIFO_DEPTH, default 16, FIFO entries; power of 2, range 2..256.
REQ-006 SHALL have port i_clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port i_rst, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-008 SHALL have port i_data, input, G_DATA_BITS bits, character to queue.
REQ-009 SHALL have port i_wr, input, 1 bit, single-cycle write strobe for i_data.
REQ-010 SHALL have port o_full, output, 1 bit, FIFO holds G_FIFO_DEPTH entries.
REQ-011 SHALL have port o_busy, output, 1 bit, frame in progress or FIFO non-empty.
REQ-012 SHALL have port o_overflow, output, 1 bit, one-cycle pulse on rejected write.
REQ-013 SHALL have port o_UART_Tx, output, 1 bit, serial line; idle high.

Function
REQ-014 Write accepted at rising edge when i_wr=1 and o_full=0; entry visible to the transmitter on the next cycle.
REQ-015 Write with o_full=1 SHALL be discarded, FIFO unchanged, o_overflow=1 the following cycle only; a same-cycle pop SHALL NOT make room for it.
REQ-016 FIFO SHALL use wrapping read/write pointers plus count; o_full = (count == G_FIFO_DEPTH), registered.
REQ-017 State machine states: IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: o_UART_Tx=1; if FIFO non-empty, pop head into shift register and enter START next cycle.
REQ-019 START: o_UART_Tx=0 for exactly G_CLK_DIV cycles, then DATA.
REQ-020 DATA: G_DATA_BITS bits sent LSB first, each held G_CLK_DIV cycles; then PARITY if G_PARITY!=0, else STOP.
REQ-021 PARITY: one bit, G_CLK_DIV cycles; even = XOR of data bits, odd = its inverse.
REQ-022 STOP: o_UART_Tx=1 for G_STOP_BITS*G_CLK_DIV cycles.
REQ-023 At end of STOP with FIFO non-empty, SHALL pop and enter START on the next cycle (no extra idle bit); else return to IDLE.
REQ-024 Bit timer SHALL be a down-counter of ceil(log2(G_CLK_DIV)) bits reloaded to G_CLK_DIV-1 at each bit start; bit counter sized for G_DATA_BITS.
REQ-025 Latency: write into empty FIFO while IDLE at edge N -> pop at edge N+1 -> o_UART_Tx falls after edge N+2.
REQ-026 o_busy=1 whenever state!=IDLE or count!=0; goes low the cycle after the final stop bit completes with FIFO empty.
REQ-027 o_UART_Tx SHALL be driven from a flop (glitch-free).
REQ-028 Frame length SHALL be (1+G_DATA_BITS+(G_PARITY!=0)+G_STOP_BITS)*G_CLK_DIV cycles.

Reset
REQ-029 While i_rst=0: state=IDLE, FIFO empty, counters 0, o_UART_Tx=1, o_full=0, o_busy=0, o_overflow=0, taking effect immediately without a clock edge.
REQ-030 Reset asserted mid-frame SHALL abort the frame and flush the FIFO; line returns high immediately.
REQ-031 Reset deassertion SHALL be synchronised internally; first write accepted on the second rising edge after release.

Verification
REQ-032 Defaults, G_CLK_DIV=4: write 0x48 -> line low 4 cycles, bits 0,0,0,1,0,0,1,0 at 4 cycles each, high 4 cycles; frame 40 cycles.
REQ-033 G_PARITY=2, write 0x07 -> parity bit 1; G_PARITY=1 -> parity bit 0; frame 44 cycles at G_CLK_DIV=4.
REQ-034 G_FIFO_DEPTH=4, 6 consecutive writes while IDLE -> first popped, 4 queued, o_full=1, one o_overflow pulse on 6th write, 5 characters transmitted.
REQ-035 Two back-to-back queued characters, G_STOP_BITS=2 -> second start bit begins exactly 8 cycles after first stop bit begins; no idle gap.
REQ-036 Reset pulled low mid-DATA with 3 queued characters -> o_UART_Tx=1 same cycle, o_busy=0; after release no further characters sent.
REQ-037 Bench SHALL deserialise o_UART_Tx with a model checking start/stop framing and parity for every character in all scenarios.
